// File: rtl/apu_reg_loader_if.sv
// Byte stream from the UART receiver into the APU register loader.
interface apu_reg_loader_if;
  logic [7:0] rx_data;
  logic       rx_valid;

  modport master (output rx_data, output rx_valid);
  modport slave  (input  rx_data, input  rx_valid);
endinterface

// File: rtl/apu_reg_loader.sv
// Decodes header/data byte pairs from the UART stream into the 32 x 8 APU
// register file, with per-channel change toggles and a header-to-data timeout.
module apu_reg_loader #(
  parameter int unsigned TIMEOUT = 8948
) (
  input  logic                 clk,
  input  logic                 rst_n,
  apu_reg_loader_if.slave      rx,
  output logic [255:0]         apu_reg_bus,
  output logic [7:0]           reg_change,
  output logic                 wr_strobe,
  output logic [4:0]           wr_addr,
  output logic                 timeout_err
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic {
    WAIT_ADDR,
    WAIT_DATA
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    pend_q, pend_d;

  logic [7:0]    regs_q [32];
  logic [7:0]    chg_q;
  logic          stb_q;
  logic [4:0]    waddr_q;
  logic          terr_q;

  logic          wr_en;
  logic          expire;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT_ADDR;
      cnt_q   <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  // Next-state logic; a byte arriving in the last counter cycle takes priority
  // over expiry, and the counter saturates rather than wrapping.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    unique case (state_q)
      WAIT_ADDR: begin
        if (rx.rx_valid && rx.rx_data[7]) begin
          state_d = WAIT_DATA;
          pend_d  = rx.rx_data[4:0];
          cnt_d   = '0;
        end
      end
      WAIT_DATA: begin
        if (rx.rx_valid) begin
          state_d = WAIT_ADDR;
        end else if (cnt_q == CNT_LAST) begin
          state_d = WAIT_ADDR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = WAIT_ADDR;
    endcase
  end

  // Output decode
  always_comb begin
    wr_en  = 1'b0;
    expire = 1'b0;
    if (state_q == WAIT_DATA) begin
      wr_en  = rx.rx_valid;
      expire = !rx.rx_valid && (cnt_q == CNT_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
      chg_q   <= '0;
      stb_q   <= 1'b0;
      waddr_q <= '0;
      terr_q  <= 1'b0;
    end else begin
      stb_q  <= wr_en;
      terr_q <= expire;
      if (wr_en) begin
        regs_q[pend_q]      <= rx.rx_data;
        chg_q[pend_q[4:2]]  <= ~chg_q[pend_q[4:2]];
        waddr_q             <= pend_q;
      end
    end
  end

  always_comb begin
    apu_reg_bus = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      apu_reg_bus[8*i +: 8] = regs_q[i];
    end
  end

  assign reg_change  = chg_q;
  assign wr_strobe   = stb_q;
  assign wr_addr     = waddr_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_apu_reg_loader.sv
// Directed bench for apu_reg_loader with a transaction-level reference model.
module tb_apu_reg_loader;
  localparam int unsigned TO = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [255:0] apu_reg_bus;
  logic [7:0]   reg_change;
  logic         wr_strobe;
  logic [4:0]   wr_addr;
  logic         timeout_err;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  apu_reg_loader_if rx_if ();

  apu_reg_loader #(.TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx          (rx_if),
    .apu_reg_bus (apu_reg_bus),
    .reg_change  (reg_change),
    .wr_strobe   (wr_strobe),
    .wr_addr     (wr_addr),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a header opens a window whose deadline is TO edges later;
  // data on any edge up to and including the deadline is written.
  logic [7:0] mem [32];
  logic [7:0] m_chg;
  logic [4:0] m_addr;
  logic       m_stb, m_err;
  bit         pend;
  logic [4:0] paddr;
  longint     cyc = 0;
  longint     deadline = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mem[i] = 8'h00;
      m_chg  = 8'h00;
      m_addr = 5'd0;
      m_stb  = 1'b0;
      m_err  = 1'b0;
      pend   = 1'b0;
    end else begin
      cyc++;
      m_stb = 1'b0;
      m_err = 1'b0;
      if (pend && rx_if.rx_valid) begin
        mem[paddr]        = rx_if.rx_data;
        m_chg[paddr / 4] = ~m_chg[paddr / 4];
        m_addr            = paddr;
        m_stb             = 1'b1;
        pend              = 1'b0;
      end else if (pend && cyc == deadline) begin
        m_err = 1'b1;
        pend  = 1'b0;
      end else if (!pend && rx_if.rx_valid && rx_if.rx_data[7]) begin
        pend     = 1'b1;
        paddr    = rx_if.rx_data[4:0];
        deadline = cyc + TO;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      logic [255:0] exp_bus;
      for (int i = 0; i < 32; i++) exp_bus[8*i +: 8] = mem[i];
      check("bus", apu_reg_bus, exp_bus);
      check("reg_change", {248'd0, reg_change}, {248'd0, m_chg});
      check("wr_strobe", {255'd0, wr_strobe}, {255'd0, m_stb});
      check("wr_addr", {251'd0, wr_addr}, {251'd0, m_addr});
      check("timeout_err", {255'd0, timeout_err}, {255'd0, m_err});
    end
  end

  // Caller sits at a negedge; the byte is sampled on the next posedge.
  task automatic send(input logic [7:0] b);
    rx_if.rx_data  = b;
    rx_if.rx_valid = 1'b1;
    @(negedge clk);
    rx_if.rx_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    rx_if.rx_data  = 8'h00;
    rx_if.rx_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_bus", apu_reg_bus, 256'd0);
    check("rst_chg", {248'd0, reg_change}, 256'd0);
    #10 rst_n = 1'b1;
    @(negedge clk);
    cmp_en = 1'b1;

    // Single write
    send(8'h80);
    send(8'h01);
    check("w0_reg0", {248'd0, apu_reg_bus[7:0]}, 256'h01);
    check("w0_chg", {248'd0, reg_change}, 256'h01);
    check("w0_stb", {255'd0, wr_strobe}, 256'd1);
    check("w0_addr", {251'd0, wr_addr}, 256'd0);
    @(negedge clk);
    check("w0_stb_low", {255'd0, wr_strobe}, 256'd0);

    // Channel mapping
    send(8'h9F); send(8'hAA);
    send(8'h87); send(8'h55);
    check("map_reg31", {248'd0, apu_reg_bus[255:248]}, 256'hAA);
    check("map_reg7", {248'd0, apu_reg_bus[63:56]}, 256'h55);
    check("map_chg", {248'd0, reg_change}, 256'h83);
    send(8'h87); send(8'h55);
    check("map_rep_chg", {248'd0, reg_change}, 256'h81);

    // Orphan byte, then data with bit7 set
    send(8'h05);
    @(negedge clk);
    send(8'h83); send(8'hFF);
    check("d7_reg3", {248'd0, apu_reg_bus[31:24]}, 256'hFF);
    check("d7_chg", {248'd0, reg_change}, 256'h80);

    // Timeout
    send(8'h82);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (timeout_err) begin
        lat = k;
        break;
      end
    end
    check("to_latency", lat, 16);
    send(8'h33);
    check("to_no_write_stb", {255'd0, wr_strobe}, 256'd0);
    check("to_reg2", {248'd0, apu_reg_bus[23:16]}, 256'h00);

    // Data in the expiry cycle wins
    send(8'h84);
    repeat (15) @(negedge clk);
    send(8'h5A);
    check("race_reg4", {248'd0, apu_reg_bus[39:32]}, 256'h5A);
    check("race_stb", {255'd0, wr_strobe}, 256'd1);
    check("race_err", {255'd0, timeout_err}, 256'd0);
    check("race_chg", {248'd0, reg_change}, 256'h82);

    // Header bits [6:5] ignored
    send(8'hE6); send(8'h11);
    check("hdr65_reg6", {248'd0, apu_reg_bus[55:48]}, 256'h11);
    check("hdr65_addr", {251'd0, wr_addr}, 256'd6);
    check("hdr65_chg", {248'd0, reg_change}, 256'h80);

    // Reset mid-transaction
    send(8'h85);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_bus", apu_reg_bus, 256'd0);
    check("mrst_chg", {248'd0, reg_change}, 256'd0);
    check("mrst_stb", {255'd0, wr_strobe}, 256'd0);
    check("mrst_err", {255'd0, timeout_err}, 256'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(8'h12);
    check("mrst_no_write", {255'd0, wr_strobe}, 256'd0);
    check("mrst_reg5", {248'd0, apu_reg_bus[47:40]}, 256'h00);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/apu_reg_loader.md
# apu_reg_loader

Serial-to-register bridge for the APU. Consumes the byte stream produced by the UART receiver, decodes address/data pairs, and maintains the 32 x 8 APU register file that feeds the rectangle, noise and other channel generators. Each write also toggles a per-channel `reg_change` line, which the channels use to restart length/envelope state. Sits directly upstream of the channel blocks in the 894,720 Hz APU clock domain.

## Interface
- `TIMEOUT`, 8948: number of `clk` cycles (about 10 ms) allowed between an address byte and its data byte.
- `clk`  in  1  APU clock, 894,720 Hz.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rx_data`  in  8  received byte; valid only when `rx_valid` = 1.
- `rx_valid`  in  1  single-cycle strobe, one per received byte.
- `apu_reg_bus`  out  256  flattened register file; register n occupies bits [8n+7:8n].
- `reg_change`  out  8  bit k toggles on every write to registers 4k..4k+3.
- `wr_strobe`  out  1  one-cycle pulse on each committed write.
- `wr_addr`  out  5  address of the last committed write.
- `timeout_err`  out  1  one-cycle pulse when an address byte expires without data.

## Operation
- The FSM has two states.
  - `WAIT_ADDR` (reset state):
    - A byte with `rx_data[7]` = 1 is a header. Latch `rx_data[4:0]` as the pending address, clear the timeout counter, and go to `WAIT_DATA`.
    - Bits [6:5] of a header are ignored.
    - A byte with bit7 = 0 is discarded silently.
  - `WAIT_DATA`:
    - The next `rx_valid` byte is data, whatever the value of bit7.
    - Write the data to `reg[pending]`, toggle `reg_change[pending[4:2]]`, pulse `wr_strobe`, load `wr_addr`, and return to `WAIT_ADDR`.
    - Each cycle without `rx_valid` increments the timeout counter.
    - When the counter reaches `TIMEOUT`-1, pulse `timeout_err`, discard the pending address, and return to `WAIT_ADDR`.
- The timeout counter is `$clog2(TIMEOUT)` bits wide and never wraps; it is cleared on each header.
- Writes are unconditional, including a write of an unchanged value. `reg_change` still toggles.
- Reset values:
  - `apu_reg_bus` = 0 (all registers 0), `reg_change` = 0, `wr_addr` = 0.
  - `wr_strobe` = 0, `timeout_err` = 0.
  - State = `WAIT_ADDR`, counter = 0.
- Reset mid-transaction drops the pending address; no write occurs.

## Timing
- Data byte strobe at edge N: the register value, `reg_change`, `wr_addr` and `wr_strobe` are all updated at edge N+1 (1-cycle latency). `wr_strobe` is high for exactly one cycle.
- Header strobe at edge N: state is `WAIT_DATA` from edge N+1. A data byte at edge N+1 (back-to-back) is accepted.
- `rx_valid` in the same cycle the counter reaches `TIMEOUT`-1: the byte wins. It is written as data and there is no `timeout_err`.
- Maximum throughput is one write per two `rx_valid` strobes; no back-pressure exists.
- All outputs are registered; there is no combinational path from `rx_*` to any output.
- Consumers sample `reg_change` as a toggle: they edge-detect by comparing against a delayed copy. No pulse-width requirement applies.

## Test plan
- Reset check: assert `rst_n` = 0 mid-stream.
  - Expect `apu_reg_bus` = 0, `reg_change` = 0, `wr_strobe` = 0 and `timeout_err` = 0 immediately, without waiting for a clock edge.
- Single write: send header 0x80, then 0x01.
  - Expect `apu_reg_bus[7:0]` = 0x01 and `reg_change` = 0x01 one cycle after the data strobe.
  - Expect `wr_strobe` high for 1 cycle and `wr_addr` = 0.
- Channel mapping: write 0x9F/0xAA, then 0x87/0x55.
  - Expect reg31 = 0xAA and reg7 = 0x55.
  - Expect `reg_change` bits 7 and 1 to toggle, with all other bits unchanged.
  - Repeat the 0x87/0x55 write: bit 1 toggles back to 0.
- Data with bit7 set, and orphan bytes:
  - Send 0x05 alone: no write.
  - Then send 0x83 followed by 0xFF: reg3 = 0xFF and `reg_change[0]` toggles.
- Timeout: with `TIMEOUT` = 16, send 0x82 and then idle.
  - Expect `timeout_err` pulsed once, 15 cycles after the header state entry.
  - Send 0x33 afterwards: no write.
- Timeout race: send the data byte exactly in the counter = `TIMEOUT`-1 cycle.
  - Expect the write to commit and no `timeout_err`.
